// File: rtl/mips_mon_pkg.sv
// Shared types for the MIPS run monitor: FSM state encoding and
// pointer/occupancy width helpers for the trace buffer.
package mips_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a completely full buffer (== depth) is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mips_trace_fifo.sv
// Synchronous trace FIFO with registered read data and an optional
// overwrite-oldest mode for ring-style capture.
module mips_trace_fifo
  import mips_mon_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter bit RING  = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        pop_valid,
  output logic [occ_width(DEPTH)-1:0] entries,
  output logic                        lost
);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] count_r;

  logic full_s;
  logic empty_s;
  logic pop_do_s;
  logic push_ok_s;
  logic overwrite_s;

  assign entries = count_r;

  // Accept/overwrite/drop decisions for this cycle
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    empty_s     = (count_r == {OCC_W{1'b0}});
    pop_do_s    = pop && !empty_s;
    // A same-cycle pop frees a slot, so a full buffer can still accept.
    push_ok_s   = push && (!full_s || pop_do_s);
    overwrite_s = push && full_s && !pop_do_s && RING;
    lost        = push && full_s && !pop_do_s;
  end

  // Pointers, occupancy and the registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {OCC_W{1'b0}};
      pop_data  <= {WIDTH{1'b0}};
      pop_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {OCC_W{1'b0}};
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_do_s;
      if (pop_do_s) begin
        pop_data <= mem_r[rd_ptr_r];
      end
      if (push_ok_s || overwrite_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      // Overwriting the oldest entry means the oldest is now the next one.
      if (pop_do_s || overwrite_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      if (push_ok_s && !pop_do_s) begin
        count_r <= count_r + OCC_W'(1'b1);
      end else if (pop_do_s && !push_ok_s) begin
        count_r <= count_r - OCC_W'(1'b1);
      end
    end
  end

  // Storage array, left unreset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (push_ok_s || overwrite_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor for single-cycle MIPS cores: traces pc/alu every RUN cycle and
// ends the run on branch-to-self (halt) or on a cycle budget.
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 32,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 50,
  parameter int CNT_W       = 16,
  parameter bit RING        = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DATA_W-1:0]           pc_in,
  input  logic [DATA_W-1:0]           alu_in,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_pc,
  output logic [DATA_W-1:0]           rd_alu,
  output logic                        rd_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        halted,
  output logic                        timed_out,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [occ_width(DEPTH)-1:0] entries,
  output logic                        dropped
);
  localparam int REP_W = $clog2(HALT_CYCLES + 1);

  mon_state_e          state_r;
  logic [DATA_W-1:0]   prev_pc_r;
  logic [REP_W-1:0]    rep_cnt_r;

  logic                run_s;
  logic                launch_s;
  logic                halt_hit_s;
  logic                budget_hit_s;
  logic                lost_s;
  logic [REP_W-1:0]    rep_next_s;
  logic [CNT_W-1:0]    cnt_next_s;
  logic [2*DATA_W-1:0] rd_data_s;

  // Next repeat count and run-ending conditions for the current sample
  always_comb begin
    run_s      = (state_r == ST_RUN);
    launch_s   = start && !run_s;
    cnt_next_s = cycle_count + CNT_W'(1'b1);
    // cycle_count == 0 marks the first RUN cycle: prev_pc is not yet valid.
    if (cycle_count == {CNT_W{1'b0}}) begin
      rep_next_s = {REP_W{1'b0}};
    end else if (pc_in == prev_pc_r) begin
      rep_next_s = rep_cnt_r + REP_W'(1'b1);
    end else begin
      rep_next_s = {REP_W{1'b0}};
    end
    halt_hit_s   = (rep_next_s == REP_W'(HALT_CYCLES));
    budget_hit_s = (cnt_next_s == CNT_W'(MAX_CYCLES));
  end

  mips_trace_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH),
    .RING  (RING)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (launch_s),
    .push      (run_s),
    .push_data ({pc_in, alu_in}),
    .pop       (rd_en),
    .pop_data  (rd_data_s),
    .pop_valid (rd_valid),
    .entries   (entries),
    .lost      (lost_s)
  );

  assign rd_pc  = rd_data_s[2*DATA_W-1:DATA_W];
  assign rd_alu = rd_data_s[DATA_W-1:0];

  // Run FSM with registered status flags and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
      dropped     <= 1'b0;
      cycle_count <= {CNT_W{1'b0}};
      prev_pc_r   <= {DATA_W{1'b0}};
      rep_cnt_r   <= {REP_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r     <= ST_RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            dropped     <= 1'b0;
            cycle_count <= {CNT_W{1'b0}};
            rep_cnt_r   <= {REP_W{1'b0}};
          end
        end
        ST_RUN: begin
          cycle_count <= cnt_next_s;
          prev_pc_r   <= pc_in;
          rep_cnt_r   <= rep_next_s;
          if (lost_s) begin
            dropped <= 1'b1;
          end
          // Halt wins over a budget expiry landing on the same sample.
          if (halt_hit_s) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            halted  <= 1'b1;
          end else if (budget_hit_s) begin
            state_r   <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: three configurations (default, ring, short budget)
// share one stimulus stream and are checked against a queue-based model.
module tb_mips_run_monitor;
  localparam int NDUT = 3;
  localparam int DEP  = 32;
  localparam int HALT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, rd_en;
  logic [15:0] pc_in, alu_in;
  logic [15:0] rd_pc [NDUT];
  logic [15:0] rd_alu [NDUT];
  logic        rd_valid [NDUT];
  logic        busy [NDUT];
  logic        done [NDUT];
  logic        halted [NDUT];
  logic        timed_out [NDUT];
  logic        dropped [NDUT];
  logic [15:0] cycle_count [NDUT];
  logic [5:0]  entries [NDUT];

  mips_run_monitor u_def (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .alu_in(alu_in), .rd_en(rd_en),
    .rd_pc(rd_pc[0]), .rd_alu(rd_alu[0]), .rd_valid(rd_valid[0]), .busy(busy[0]), .done(done[0]),
    .halted(halted[0]), .timed_out(timed_out[0]), .cycle_count(cycle_count[0]),
    .entries(entries[0]), .dropped(dropped[0]));

  mips_run_monitor #(.RING(1'b1)) u_ring (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .alu_in(alu_in), .rd_en(rd_en),
    .rd_pc(rd_pc[1]), .rd_alu(rd_alu[1]), .rd_valid(rd_valid[1]), .busy(busy[1]), .done(done[1]),
    .halted(halted[1]), .timed_out(timed_out[1]), .cycle_count(cycle_count[1]),
    .entries(entries[1]), .dropped(dropped[1]));

  mips_run_monitor #(.MAX_CYCLES(8)) u_max8 (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .alu_in(alu_in), .rd_en(rd_en),
    .rd_pc(rd_pc[2]), .rd_alu(rd_alu[2]), .rd_valid(rd_valid[2]), .busy(busy[2]), .done(done[2]),
    .halted(halted[2]), .timed_out(timed_out[2]), .cycle_count(cycle_count[2]),
    .entries(entries[2]), .dropped(dropped[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: run phase, trace queue and the pcs seen this run
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  int          cfg_ring [NDUT] = '{0, 1, 0};
  int          cfg_max  [NDUT] = '{50, 50, 8};
  int          m_phase [NDUT];
  logic [31:0] m_q [NDUT][$];
  logic [15:0] m_hist [NDUT][$];
  bit          m_valid [NDUT];
  bit          m_halt [NDUT];
  bit          m_to [NDUT];
  bit          m_drop [NDUT];
  logic [15:0] m_rdpc [NDUT];
  logic [15:0] m_rdalu [NDUT];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit re,
                            input logic [15:0] p, input logic [15:0] a);
    logic [31:0] e;
    int run_len;
    for (int c = 0; c < NDUT; c++) begin
      if (r) begin
        m_phase[c] = M_IDLE;
        m_q[c].delete();
        m_hist[c].delete();
        m_valid[c] = 1'b0; m_halt[c] = 1'b0; m_to[c] = 1'b0; m_drop[c] = 1'b0;
        m_rdpc[c] = 16'd0; m_rdalu[c] = 16'd0;
      end else if (s && m_phase[c] != M_RUN) begin
        m_phase[c] = M_RUN;
        m_q[c].delete();
        m_hist[c].delete();
        m_valid[c] = 1'b0; m_halt[c] = 1'b0; m_to[c] = 1'b0; m_drop[c] = 1'b0;
      end else begin
        if (re && m_q[c].size() > 0) begin
          e = m_q[c].pop_front();
          m_valid[c] = 1'b1;
          m_rdpc[c]  = e[31:16];
          m_rdalu[c] = e[15:0];
        end else begin
          m_valid[c] = 1'b0;
        end
        if (m_phase[c] == M_RUN) begin
          if (m_q[c].size() < DEP) begin
            m_q[c].push_back({p, a});
          end else begin
            m_drop[c] = 1'b1;
            if (cfg_ring[c] != 0) begin
              void'(m_q[c].pop_front());
              m_q[c].push_back({p, a});
            end
          end
          m_hist[c].push_back(p);
          // halt = the last HALT+1 samples of this run share one pc
          run_len = 1;
          for (int k = m_hist[c].size() - 2; k >= 0; k--) begin
            if (m_hist[c][k] != p) break;
            run_len++;
          end
          if (run_len - 1 >= HALT) begin
            m_phase[c] = M_DONE; m_halt[c] = 1'b1;
          end else if (m_hist[c].size() == cfg_max[c]) begin
            m_phase[c] = M_DONE; m_to[c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NDUT; c++) begin
      check($sformatf("model_dut%0d", c),
        {4'b0, rd_valid[c], rd_pc[c], rd_alu[c], busy[c], done[c], halted[c], timed_out[c],
         dropped[c], cycle_count[c], entries[c]},
        {4'b0, m_valid[c], m_rdpc[c], m_rdalu[c], m_phase[c] == M_RUN, m_phase[c] == M_DONE,
         m_halt[c], m_to[c], m_drop[c], 16'(m_hist[c].size()), 6'(m_q[c].size())});
    end
  endtask

  // Drive one cycle: inputs set before the posedge, outputs checked on the negedge.
  task automatic step(input bit r, input bit s, input bit re, input logic [15:0] p);
    reset  = r;
    start  = s;
    rd_en  = re;
    pc_in  = p;
    alu_in = p ^ 16'h5a3c;
    model_step(r, s, re, p, p ^ 16'h5a3c);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    bit          start;
    logic [15:0] pc;
    bit          rd_en;
    bit          e_busy;
    bit          e_done;
    bit          e_halt;
    logic [15:0] e_cnt;
    logic [5:0]  e_ent;
    bit          e_valid;
    logic [15:0] e_rdpc;
  } vec_t;

  vec_t        vecs [18];
  logic [15:0] pcs1 [8] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd6, 16'd6, 16'd6, 16'd6};

  initial begin
    bit          rr, rs, rre;
    logic [15:0] rpc;

    vecs[0] = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 6'd0, 1'b0, 16'd0};
    for (int i = 0; i < 8; i++)
      vecs[i+1] = '{1'b0, pcs1[i], 1'b0, i < 7, i == 7, i == 7, 16'(i + 1), 6'(i + 1), 1'b0, 16'd0};
    for (int k = 0; k < 8; k++)
      vecs[9+k] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd8, 6'(7 - k), 1'b1, pcs1[k]};
    vecs[17] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd8, 6'd0, 1'b0, 16'd6};

    // Reset state
    step(1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'd0);
    for (int c = 0; c < NDUT; c++)
      check("reset_state", 64'({rd_valid[c], rd_pc[c], busy[c], done[c], halted[c], timed_out[c],
                               dropped[c], cycle_count[c], entries[c]}), 64'd0);

    // Test 1: halt on branch-to-self, then drain in order
    for (int i = 0; i < 18; i++) begin
      step(1'b0, vecs[i].start, vecs[i].rd_en, vecs[i].pc);
      check($sformatf("t1_row%0d", i),
        64'({busy[0], done[0], halted[0], timed_out[0], dropped[0], cycle_count[0], entries[0],
             rd_valid[0], rd_pc[0]}),
        64'({vecs[i].e_busy, vecs[i].e_done, vecs[i].e_halt, 1'b0, 1'b0, vecs[i].e_cnt,
             vecs[i].e_ent, vecs[i].e_valid, vecs[i].e_rdpc}));
    end
    check("t6_halt_beats_budget", 64'({halted[2], timed_out[2]}), 64'(2'b10));

    // Tests 2/3: budget timeout, overflow with and without ring overwrite
    step(1'b0, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 60 && !done[0]; i++) step(1'b0, 1'b0, 1'b0, 16'(2 * i));
    check("t2_end", 64'({done[0], timed_out[0], halted[0], cycle_count[0], entries[0], dropped[0]}),
          64'({1'b1, 1'b1, 1'b0, 16'd50, 6'd32, 1'b1}));
    check("t3_end", 64'({done[1], timed_out[1], halted[1], cycle_count[1], entries[1], dropped[1]}),
          64'({1'b1, 1'b1, 1'b0, 16'd50, 6'd32, 1'b1}));
    for (int k = 0; k < 33; k++) begin
      step(1'b0, 1'b0, 1'b1, 16'd0);
      if (k == 0)  check("t2_first_pop", 64'({rd_valid[0], rd_pc[0]}), 64'({1'b1, 16'd0}));
      if (k == 31) check("t2_last_pop", 64'({rd_valid[0], rd_pc[0]}), 64'({1'b1, 16'd62}));
      if (k == 32) check("t2_empty_pop", 64'(rd_valid[0]), 64'd0);
      if (k < 32) check("t3_ring_pop", 64'({rd_valid[1], rd_pc[1]}), 64'({1'b1, 16'(36 + 2 * k)}));
      else        check("t3_ring_empty", 64'(rd_valid[1]), 64'd0);
    end

    // Test 4: full buffer with a pop each cycle keeps accepting
    step(1'b0, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b0, 16'(2 * i));
    check("t4_full", 64'({entries[0], dropped[0]}), 64'({6'd32, 1'b0}));
    for (int i = 32; i < 35; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'(2 * i));
      check("t4_pop_push", 64'({entries[0], dropped[0], rd_valid[0], rd_pc[0]}),
            64'({6'd32, 1'b0, 1'b1, 16'(2 * (i - 32))}));
    end
    for (int i = 35; i < 60 && !done[0]; i++) step(1'b0, 1'b0, 1'b0, 16'(2 * i));
    check("t4_end", 64'({done[0], timed_out[0], dropped[0], entries[0]}), 64'({3'b111, 6'd32}));
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 1'b0, 1'b1, 16'd0);
      if (k == 0)  check("t4_oldest", 64'({rd_valid[0], rd_pc[0]}), 64'({1'b1, 16'd6}));
      if (k == 31) check("t4_newest", 64'({rd_valid[0], rd_pc[0]}), 64'({1'b1, 16'd68}));
    end

    // Test 5: start ignored while busy, reset mid-run
    step(1'b0, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i == 4, 1'b0, 16'(100 + 2 * i));
      if (i == 4) check("t5_start_ignored", 64'({busy[0], cycle_count[0], entries[0]}),
                        64'({1'b1, 16'd5, 6'd5}));
    end
    step(1'b1, 1'b0, 1'b0, 16'd120);
    for (int c = 0; c < NDUT; c++)
      check("t5_reset", 64'({busy[c], done[c], entries[c], cycle_count[c]}), 64'd0);
    step(1'b0, 1'b0, 1'b1, 16'd0);
    check("t5_pop_empty", 64'(rd_valid[0]), 64'd0);

    // Test 6: short budget coinciding with halt, then restart from DONE
    step(1'b0, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, pcs1[i]);
    check("t6_done", 64'({halted[2], timed_out[2], done[2], cycle_count[2], entries[2]}),
          64'({3'b101, 16'd8, 6'd8}));
    step(1'b0, 1'b1, 1'b0, 16'd0);
    check("t6_restart", 64'({busy[2], done[2], halted[2], entries[2], cycle_count[2]}),
          64'({3'b100, 6'd0, 16'd0}));

    // Randomized traffic checked against the model every cycle
    rpc = 16'd0;
    for (int n = 0; n < 3000; n++) begin
      rr  = ($urandom_range(0, 199) == 0);
      rs  = ($urandom_range(0, 19) == 0);
      rre = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) rpc = 16'($urandom_range(0, 15) * 2);
      step(rr, rs, rre, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
